// File: rtl/ofm_pkg.sv
// Shared definitions for the outbound frame mover: word field positions, FSM states
// and the last-beat keep generator.
package ofm_pkg;

    localparam int unsigned CTRL_W        = 34;
    localparam int unsigned CTRL_LEN_LSB  = 0;
    localparam int unsigned CTRL_LEN_MSB  = 15;
    localparam int unsigned CTRL_DROP_BIT = 32;

    localparam int unsigned BEAT_W        = 73;
    localparam int unsigned BEAT_DATA_W   = 64;
    localparam int unsigned BEAT_KEEP_LSB = 64;
    localparam int unsigned BEAT_KEEP_MSB = 71;
    localparam int unsigned BEAT_LAST_BIT = 72;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_XFER = 2'd1,
        ST_DROP = 2'd2
    } state_e;

    // One keep bit per remaining byte; rem >= 8 yields a full beat.
    function automatic logic [7:0] len_to_keep(input logic [3:0] rem);
        logic [7:0] keep;
        for (int i = 0; i < 8; i++) begin
            keep[i] = (4'(i) < rem);
        end
        return keep;
    endfunction

endpackage

// File: rtl/ofm_tx_mover.sv
// Moves packets from the info/data FWFT FIFOs into the MAC transmit FIFO, trimming the
// last beat to the control-word length, discarding dropped packets and counting outcomes.
module ofm_tx_mover
    import ofm_pkg::*;
#(
    parameter int unsigned LEN_W = 16,
    parameter int unsigned CNT_W = 32
) (
    input  logic                i_tx_clk,
    input  logic                i_sys_rst_n,
    input  logic                i_enable,
    input  logic [CTRL_W-1:0]   i_ctrl_fifo_rdata,
    input  logic                i_ctrl_fifo_empty,
    output logic                o_ctrl_fifo_rden,
    input  logic [BEAT_W-1:0]   i_data_fifo_rdata,
    input  logic                i_data_fifo_empty,
    output logic                o_data_fifo_rden,
    output logic [BEAT_W-1:0]   o_tx_fifo_wdata,
    output logic                o_tx_fifo_wren,
    input  logic                i_tx_fifo_afull,
    output logic                o_busy,
    output logic [CNT_W-1:0]    o_pkt_cnt,
    output logic [CNT_W-1:0]    o_drop_cnt,
    output logic [CNT_W-1:0]    o_len_err_cnt
);

    state_e              r_state, w_state_nxt;
    logic [LEN_W-1:0]    r_rem, w_rem_nxt;
    logic                r_wren, w_wren_nxt;
    logic [BEAT_W-1:0]   r_wdata, w_wdata_nxt;
    logic [CNT_W-1:0]    r_pkt_cnt, r_drop_cnt, r_len_err_cnt;
    logic                w_pkt_inc, w_drop_inc, w_err_inc;
    logic                w_ctrl_rden, w_data_rden;

    logic [LEN_W-1:0]    w_ctrl_len;
    logic                w_ctrl_drop;
    logic                w_src_last;
    logic                w_rem_le8;
    logic [7:0]          w_final_keep;
    logic [BEAT_DATA_W-1:0] w_src_data;
    logic [7:0]          w_src_keep;
    logic                w_unused_ctrl;

    assign w_ctrl_len    = i_ctrl_fifo_rdata[CTRL_LEN_LSB +: LEN_W];
    assign w_ctrl_drop   = i_ctrl_fifo_rdata[CTRL_DROP_BIT];
    assign w_unused_ctrl = ^{i_ctrl_fifo_rdata[33], i_ctrl_fifo_rdata[31:16]};
    assign w_src_last    = i_data_fifo_rdata[BEAT_LAST_BIT];
    assign w_src_keep    = i_data_fifo_rdata[BEAT_KEEP_MSB:BEAT_KEEP_LSB];
    assign w_src_data    = i_data_fifo_rdata[BEAT_DATA_W-1:0];
    assign w_rem_le8     = (r_rem <= LEN_W'(8));
    assign w_final_keep  = len_to_keep(r_rem[3:0]);

    always_comb begin
        w_state_nxt = r_state;
        w_rem_nxt   = r_rem;
        w_wren_nxt  = 1'b0;
        w_wdata_nxt = r_wdata;
        w_ctrl_rden = 1'b0;
        w_data_rden = 1'b0;
        w_pkt_inc   = 1'b0;
        w_drop_inc  = 1'b0;
        w_err_inc   = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (i_enable && !i_ctrl_fifo_empty && !i_tx_fifo_afull) begin
                    w_ctrl_rden = 1'b1;
                    w_rem_nxt   = w_ctrl_len;
                    if (w_ctrl_drop || (w_ctrl_len == '0)) begin
                        w_state_nxt = ST_DROP;
                        w_drop_inc  = 1'b1;
                    end else begin
                        w_state_nxt = ST_XFER;
                    end
                end
            end

            ST_XFER: begin
                w_data_rden = !i_data_fifo_empty && !i_tx_fifo_afull;
                if (w_data_rden) begin
                    w_wren_nxt = 1'b1;
                    if (w_rem_le8) begin
                        // Length reached: close the frame regardless of the source last bit.
                        w_wdata_nxt = {1'b1, w_final_keep, w_src_data};
                        w_pkt_inc   = 1'b1;
                        if (w_src_last) begin
                            w_state_nxt = ST_IDLE;
                        end else begin
                            w_err_inc   = 1'b1;
                            w_state_nxt = ST_DROP;
                        end
                    end else if (w_src_last) begin
                        w_wdata_nxt = i_data_fifo_rdata;
                        w_pkt_inc   = 1'b1;
                        w_err_inc   = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_wdata_nxt = {1'b0, w_src_keep, w_src_data};
                        w_rem_nxt   = r_rem - LEN_W'(8);
                    end
                end
            end

            ST_DROP: begin
                // Flushing never writes, so transmit backpressure is irrelevant here.
                w_data_rden = !i_data_fifo_empty;
                if (w_data_rden && w_src_last) begin
                    w_state_nxt = ST_IDLE;
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_tx_clk or negedge i_sys_rst_n) begin
        if (!i_sys_rst_n) begin
            r_state       <= ST_IDLE;
            r_rem         <= '0;
            r_wren        <= 1'b0;
            r_wdata       <= '0;
            r_pkt_cnt     <= '0;
            r_drop_cnt    <= '0;
            r_len_err_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_rem   <= w_rem_nxt;
            r_wren  <= w_wren_nxt;
            r_wdata <= w_wdata_nxt;
            if (w_pkt_inc) begin
                r_pkt_cnt <= r_pkt_cnt + CNT_W'(1);
            end
            if (w_drop_inc) begin
                r_drop_cnt <= r_drop_cnt + CNT_W'(1);
            end
            if (w_err_inc) begin
                r_len_err_cnt <= r_len_err_cnt + CNT_W'(1);
            end
        end
    end

    // Pops are held off while reset is asserted so the FIFOs see no spurious reads.
    assign o_ctrl_fifo_rden = w_ctrl_rden && i_sys_rst_n;
    assign o_data_fifo_rden = w_data_rden && i_sys_rst_n;
    assign o_tx_fifo_wdata  = r_wdata;
    assign o_tx_fifo_wren   = r_wren;
    assign o_busy           = (r_state != ST_IDLE);
    assign o_pkt_cnt        = r_pkt_cnt;
    assign o_drop_cnt       = r_drop_cnt;
    assign o_len_err_cnt    = r_len_err_cnt;

endmodule

// File: tb/tb_ofm_tx_mover.sv
// Directed and randomized bench for ofm_tx_mover with FWFT FIFO models on both sources
// and a packet-level reference model for the random phase.
module tb_ofm_tx_mover;

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic [33:0] ctrl_rdata;
    logic        ctrl_empty;
    logic        ctrl_rden;
    logic [72:0] data_rdata;
    logic        data_empty;
    logic        data_rden;
    logic [72:0] wdata;
    logic        wren;
    logic        afull;
    logic        busy;
    logic [31:0] pkt_cnt;
    logic [31:0] drop_cnt;
    logic [31:0] err_cnt;

    logic [33:0] ctrl_q[$];
    logic [72:0] data_q[$];
    logic [72:0] out_q[$];
    logic [72:0] exp_q[$];
    logic [31:0] e_pkt, e_drop, e_err;
    int          n_vec, n_bad;
    bit          stall;
    bit          hide_d;

    ofm_tx_mover #(.LEN_W(16), .CNT_W(32)) dut (
        .i_tx_clk          (clk),
        .i_sys_rst_n       (rst_n),
        .i_enable          (enable),
        .i_ctrl_fifo_rdata (ctrl_rdata),
        .i_ctrl_fifo_empty (ctrl_empty),
        .o_ctrl_fifo_rden  (ctrl_rden),
        .i_data_fifo_rdata (data_rdata),
        .i_data_fifo_empty (data_empty),
        .o_data_fifo_rden  (data_rden),
        .o_tx_fifo_wdata   (wdata),
        .o_tx_fifo_wren    (wren),
        .i_tx_fifo_afull   (afull),
        .o_busy            (busy),
        .o_pkt_cnt         (pkt_cnt),
        .o_drop_cnt        (drop_cnt),
        .o_len_err_cnt     (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] bd(input int tag, input int i);
        return {16'(tag), 16'(i), 32'hC0DE_0000 | 32'(i)};
    endfunction

    function automatic logic [7:0] kp(input int rem);
        int v;
        v = (rem >= 8) ? 255 : (1 << rem) - 1;
        return 8'(v);
    endfunction

    task automatic refresh();
        if (stall) begin
            afull  = ($urandom_range(0, 3) == 0);
            hide_d = ($urandom_range(0, 3) == 0);
        end else begin
            afull  = 1'b0;
            hide_d = 1'b0;
        end
        ctrl_empty = (ctrl_q.size() == 0);
        ctrl_rdata = ctrl_empty ? 34'h0 : ctrl_q[0];
        data_empty = (data_q.size() == 0) || hide_d;
        data_rdata = (data_q.size() == 0) ? 73'h0 : data_q[0];
    endtask

    // One clock: sample DUT at negedge, retire pops just after posedge.
    task automatic tick();
        bit pc, pd;
        @(negedge clk);
        pc = ctrl_rden;
        pd = data_rden;
        if (wren) out_q.push_back(wdata);
        @(posedge clk);
        #1;
        if (pc && ctrl_q.size() != 0) void'(ctrl_q.pop_front());
        if (pd && data_q.size() != 0) void'(data_q.pop_front());
        refresh();
    endtask

    task automatic add_pkt(input int len, input bit drop, input int nb, input logic [7:0] lkeep,
                           input int tag);
        logic [72:0] b;
        int rem;
        bit done;
        ctrl_q.push_back({1'b1, drop, 16'hBEEF, 16'(len)});
        rem  = len;
        done = drop || (len == 0);
        if (done) e_drop++;
        for (int i = 0; i < nb; i++) begin
            b = {(i == nb - 1), (i == nb - 1) ? lkeep : 8'hFF, bd(tag, i)};
            data_q.push_back(b);
            if (!done) begin
                if (rem <= 8) begin
                    exp_q.push_back({1'b1, kp(rem), b[63:0]});
                    e_pkt++;
                    if (!b[72]) e_err++;
                    done = 1'b1;
                end else if (b[72]) begin
                    exp_q.push_back(b);
                    e_pkt++;
                    e_err++;
                    done = 1'b1;
                end else begin
                    exp_q.push_back({1'b0, b[71:0]});
                    rem -= 8;
                end
            end
        end
        refresh();
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while (n < budget && !(ctrl_q.size() == 0 && data_q.size() == 0 && busy == 1'b0)) begin
            tick();
            n++;
        end
        n_vec++;
        if (n >= budget) begin
            n_bad++;
            $display("FAIL drain_timeout: ctrl_q=%0d data_q=%0d busy=%0b, required idle",
                     ctrl_q.size(), data_q.size(), busy);
        end
        repeat (3) tick();
    endtask

    task automatic clear_logs();
        out_q.delete();
        exp_q.delete();
    endtask

    task automatic test_reset();
        enable = 1'b1;
        ctrl_q.push_back(34'h0_0000_0040);
        refresh();
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #3;
        n_vec++;
        if ({wren, wdata, busy, ctrl_rden, data_rden} !== 77'h0) begin
            n_bad++;
            $display("FAIL reset_outputs: wren=%0b wdata=%h busy=%0b rden=%0b/%0b, required 0",
                     wren, wdata, busy, ctrl_rden, data_rden);
        end
        n_vec++;
        if ({pkt_cnt, drop_cnt, err_cnt} !== 96'h0) begin
            n_bad++;
            $display("FAIL reset_counters: %0d %0d %0d, required 0 0 0",
                     pkt_cnt, drop_cnt, err_cnt);
        end
        ctrl_q.delete();
        refresh();
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_full_len();
        logic [72:0] e;
        clear_logs();
        add_pkt(64, 1'b0, 8, 8'hFF, 1);
        drain(200);
        n_vec++;
        if (out_q.size() !== 8) begin
            n_bad++;
            $display("FAIL full_len_count: got %0d writes, required 8", out_q.size());
        end
        for (int i = 0; i < out_q.size(); i++) begin
            e = {(i == 7), 8'hFF, bd(1, i)};
            n_vec++;
            if (out_q[i] !== e) begin
                n_bad++;
                $display("FAIL full_len_beat%0d: got %h, required %h", i, out_q[i], e);
            end
        end
        n_vec++;
        if ({pkt_cnt, drop_cnt, err_cnt} !== {32'd1, 32'd0, 32'd0}) begin
            n_bad++;
            $display("FAIL full_len_counters: %0d %0d %0d, required 1 0 0",
                     pkt_cnt, drop_cnt, err_cnt);
        end
    endtask

    task automatic test_partial_keep();
        clear_logs();
        add_pkt(61, 1'b0, 8, 8'h1F, 2);
        drain(200);
        n_vec++;
        if (out_q.size() !== 8) begin
            n_bad++;
            $display("FAIL partial_count: got %0d writes, required 8", out_q.size());
        end else begin
            n_vec++;
            if (out_q[7] !== {1'b1, 8'h1F, bd(2, 7)}) begin
                n_bad++;
                $display("FAIL partial_final: got %h, required %h", out_q[7],
                         {1'b1, 8'h1F, bd(2, 7)});
            end
            n_vec++;
            if (out_q[6] !== {1'b0, 8'hFF, bd(2, 6)}) begin
                n_bad++;
                $display("FAIL partial_beat6: got %h, required %h", out_q[6],
                         {1'b0, 8'hFF, bd(2, 6)});
            end
        end
        n_vec++;
        if (pkt_cnt !== 32'd2) begin
            n_bad++;
            $display("FAIL partial_pkt_cnt: got %0d, required 2", pkt_cnt);
        end
    endtask

    task automatic test_drop();
        clear_logs();
        add_pkt(100, 1'b1, 13, 8'hFF, 3);
        add_pkt(16, 1'b0, 2, 8'hFF, 4);
        drain(300);
        n_vec++;
        if (out_q.size() !== 2) begin
            n_bad++;
            $display("FAIL drop_writes: got %0d writes, required 2", out_q.size());
        end else begin
            n_vec++;
            if (out_q[0] !== {1'b0, 8'hFF, bd(4, 0)} || out_q[1] !== {1'b1, 8'hFF, bd(4, 1)}) begin
                n_bad++;
                $display("FAIL drop_next_pkt: got %h %h, required %h %h", out_q[0], out_q[1],
                         {1'b0, 8'hFF, bd(4, 0)}, {1'b1, 8'hFF, bd(4, 1)});
            end
        end
        n_vec++;
        if ({pkt_cnt, drop_cnt, err_cnt} !== {32'd3, 32'd1, 32'd0}) begin
            n_bad++;
            $display("FAIL drop_counters: %0d %0d %0d, required 3 1 0",
                     pkt_cnt, drop_cnt, err_cnt);
        end
    endtask

    task automatic test_short_len();
        clear_logs();
        add_pkt(16, 1'b0, 4, 8'hFF, 5);
        drain(200);
        n_vec++;
        if (out_q.size() !== 2) begin
            n_bad++;
            $display("FAIL short_len_writes: got %0d, required 2", out_q.size());
        end else begin
            n_vec++;
            if (out_q[1] !== {1'b1, 8'hFF, bd(5, 1)}) begin
                n_bad++;
                $display("FAIL short_len_final: got %h, required %h", out_q[1],
                         {1'b1, 8'hFF, bd(5, 1)});
            end
        end
        n_vec++;
        if ({pkt_cnt, err_cnt, 32'(data_q.size())} !== {32'd4, 32'd1, 32'd0}) begin
            n_bad++;
            $display("FAIL short_len_state: pkt=%0d err=%0d left=%0d, required 4 1 0",
                     pkt_cnt, err_cnt, data_q.size());
        end
    endtask

    task automatic test_early_last();
        clear_logs();
        add_pkt(40, 1'b0, 3, 8'h0F, 6);
        drain(200);
        n_vec++;
        if (out_q.size() !== 3) begin
            n_bad++;
            $display("FAIL early_last_writes: got %0d, required 3", out_q.size());
        end else begin
            n_vec++;
            if (out_q[2] !== {1'b1, 8'h0F, bd(6, 2)} || out_q[1] !== {1'b0, 8'hFF, bd(6, 1)}) begin
                n_bad++;
                $display("FAIL early_last_beats: got %h %h, required %h %h", out_q[1], out_q[2],
                         {1'b0, 8'hFF, bd(6, 1)}, {1'b1, 8'h0F, bd(6, 2)});
            end
        end
        n_vec++;
        if ({pkt_cnt, err_cnt, 31'h0, busy} !== {32'd5, 32'd2, 32'd0}) begin
            n_bad++;
            $display("FAIL early_last_state: pkt=%0d err=%0d busy=%0b, required 5 2 0",
                     pkt_cnt, err_cnt, busy);
        end
    endtask

    task automatic test_back_to_back();
        logic [72:0] e[4];
        clear_logs();
        enable = 1'b0;
        add_pkt(8, 1'b0, 1, 8'hFF, 7);
        add_pkt(9, 1'b0, 2, 8'hFF, 8);
        add_pkt(0, 1'b0, 1, 8'hFF, 9);
        add_pkt(1, 1'b0, 1, 8'h01, 10);
        repeat (10) tick();
        n_vec++;
        if (ctrl_q.size() !== 4 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL enable_low: ctrl_q=%0d busy=%0b, required 4 0", ctrl_q.size(), busy);
        end
        enable = 1'b1;
        drain(200);
        e[0] = {1'b1, 8'hFF, bd(7, 0)};
        e[1] = {1'b0, 8'hFF, bd(8, 0)};
        e[2] = {1'b1, 8'h01, bd(8, 1)};
        e[3] = {1'b1, 8'h01, bd(10, 0)};
        n_vec++;
        if (out_q.size() !== 4) begin
            n_bad++;
            $display("FAIL b2b_writes: got %0d, required 4", out_q.size());
        end
        for (int i = 0; i < out_q.size() && i < 4; i++) begin
            n_vec++;
            if (out_q[i] !== e[i]) begin
                n_bad++;
                $display("FAIL b2b_beat%0d: got %h, required %h", i, out_q[i], e[i]);
            end
        end
        n_vec++;
        if ({pkt_cnt, drop_cnt, err_cnt} !== {32'd8, 32'd2, 32'd2}) begin
            n_bad++;
            $display("FAIL b2b_counters: %0d %0d %0d, required 8 2 2",
                     pkt_cnt, drop_cnt, err_cnt);
        end
    endtask

    task automatic add_random(input int tag);
        int len, nbn, nb, mode;
        bit drop;
        len  = $urandom_range(0, 70);
        drop = ($urandom_range(0, 7) == 0);
        nbn  = (len == 0) ? 1 : (len + 7) / 8;
        mode = $urandom_range(0, 3);
        if (mode == 0) nb = nbn + $urandom_range(1, 2);
        else if (mode == 1 && nbn > 1) nb = $urandom_range(1, nbn - 1);
        else nb = nbn;
        add_pkt(len, drop, nb, 8'($urandom_range(1, 255)), tag);
    endtask

    task automatic test_random_reset();
        int n;
        stall = 1'b1;
        for (int k = 0; k < 10; k++) add_random(100 + k);
        n = 0;
        while (n < 2000 && !(busy && out_q.size() >= 3)) begin
            tick();
            n++;
        end
        n_vec++;
        if (n >= 2000) begin
            n_bad++;
            $display("FAIL midpkt_timeout: busy=%0b writes=%0d, required busy with writes",
                     busy, out_q.size());
        end
        #2 rst_n = 1'b0;
        #1;
        n_vec++;
        if ({wren, wdata, busy, ctrl_rden, data_rden} !== 77'h0) begin
            n_bad++;
            $display("FAIL midpkt_reset_outputs: wren=%0b wdata=%h busy=%0b rden=%0b/%0b",
                     wren, wdata, busy, ctrl_rden, data_rden);
        end
        n_vec++;
        if ({pkt_cnt, drop_cnt, err_cnt} !== 96'h0) begin
            n_bad++;
            $display("FAIL midpkt_reset_counters: %0d %0d %0d, required 0 0 0",
                     pkt_cnt, drop_cnt, err_cnt);
        end
        ctrl_q.delete();
        data_q.delete();
        clear_logs();
        e_pkt = 0;
        e_drop = 0;
        e_err = 0;
        stall = 1'b0;
        refresh();
        repeat (2) tick();
        rst_n = 1'b1;
        stall = 1'b1;
        for (int k = 0; k < 50; k++) add_random(200 + k);
        drain(20000);
        stall = 1'b0;
        n_vec++;
        if (out_q.size() !== exp_q.size()) begin
            n_bad++;
            $display("FAIL random_count: got %0d writes, required %0d", out_q.size(), exp_q.size());
        end
        for (int i = 0; i < out_q.size() && i < exp_q.size(); i++) begin
            n_vec++;
            if (out_q[i] !== exp_q[i]) begin
                n_bad++;
                $display("FAIL random_beat%0d: got %h, required %h", i, out_q[i], exp_q[i]);
            end
        end
        n_vec++;
        if ({pkt_cnt, drop_cnt, err_cnt} !== {e_pkt, e_drop, e_err}) begin
            n_bad++;
            $display("FAIL random_counters: %0d %0d %0d, required %0d %0d %0d",
                     pkt_cnt, drop_cnt, err_cnt, e_pkt, e_drop, e_err);
        end
    endtask

    initial begin
        n_vec  = 0;
        n_bad  = 0;
        e_pkt  = 0;
        e_drop = 0;
        e_err  = 0;
        stall  = 1'b0;
        hide_d = 1'b0;
        afull  = 1'b0;
        enable = 1'b0;
        refresh();
        test_reset();
        test_full_len();
        test_partial_keep();
        test_drop();
        test_short_len();
        test_early_last();
        test_back_to_back();
        test_random_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/ofm_tx_mover.md
Name: ofm_tx_mover

Overview:
- Sits in the tx_clk domain, between the outbound packet-info/data async FIFOs and the 73-bit MAC transmit FIFO.
- For each packet it pops one 34-bit control word from the info FIFO, then moves that packet's data beats from the data FIFO into the transmit FIFO.
- Enforces the packet byte length on the last beat (tlast, tkeep), discards packets flagged for drop, flushes malformed packets, and keeps per-packet statistics.

Parameters:
- LEN_W, 16, width of the byte-length field in the control word and of the remaining-byte counter.
- CNT_W, 32, width of each statistics counter.

Ports:
- tx_clk  in  1  sole clock.
- sys_rst_n  in  1  asynchronous active-low reset.
- enable  in  1  allows new packets to start.
- ctrl_fifo_rdata  in  34  control word: [15:0] byte length, [32] drop flag, [33],[31:16] reserved (ignored).
- ctrl_fifo_empty  in  1  info FIFO empty.
- ctrl_fifo_rden  out  1  pops the info FIFO.
- data_fifo_rdata  in  73  [72] last, [71:64] keep, [63:0] data.
- data_fifo_empty  in  1  data FIFO empty.
- data_fifo_rden  out  1  pops the data FIFO.
- tx_fifo_wdata  out  73  same layout as data_fifo_rdata.
- tx_fifo_wren  out  1  writes the transmit FIFO.
- tx_fifo_afull  in  1  transmit FIFO prog_full.
- busy  out  1  state != IDLE.
- pkt_cnt  out  CNT_W  packets forwarded.
- drop_cnt  out  CNT_W  packets discarded (drop flag or zero length).
- len_err_cnt  out  CNT_W  packets with a length/last mismatch.

Behaviour:
- FIFO interface: both source FIFOs are first-word-fall-through. rdata is valid whenever empty=0, and rden=1 consumes that word in the same cycle.
- rden outputs are combinational. Both are gated internally with ~empty, so they never assert while the FIFO is empty.
- Reset: state=IDLE. All outputs 0: rden, tx_fifo_wren, tx_fifo_wdata, busy, counters. Reset mid-packet abandons the packet; the FIFOs are reset by their own reset.
- IDLE:
  - If enable & ~ctrl_fifo_empty & ~tx_fifo_afull: assert ctrl_fifo_rden for one cycle and latch rem = len.
  - Next state is DROP if the drop flag is set or len==0; otherwise XFER.
  - drop_cnt increments on entering DROP from IDLE.
- XFER:
  - data_fifo_rden = ~data_fifo_empty & ~tx_fifo_afull.
  - Each popped beat is registered to tx_fifo_wdata, with tx_fifo_wren=1 on the next cycle. Latency is 1 cycle; wren is 0 otherwise. tx_fifo_afull must assert at least 2 entries before full.
  - Normal beat (rem > 8): pass the beat through with last forced to 0. rem -= 8.
  - Final beat (rem <= 8): write last=1, keep = (rem==8) ? 8'hFF : (8'h01<<rem)-1, data unchanged.
    - If the source last=1: pkt_cnt++, go to IDLE.
    - If the source last=0: len_err_cnt++, pkt_cnt++, go to DROP to flush the remainder.
  - Early last (source last=1 while rem > 8): write the beat as-is with last=1 and source keep. len_err_cnt++, pkt_cnt++, go to IDLE.
- DROP: data_fifo_rden = ~data_fifo_empty, ignoring afull. Nothing is written. Go to IDLE on the popped beat with last=1.
- Backpressure:
  - afull high mid-packet stalls pops; no beat is lost or duplicated.
  - data_fifo_empty mid-packet stalls without timeout.
- enable low only blocks IDLE exit. A packet in progress completes.
- Counters wrap at 2^CNT_W. Each counter increments at most once per cycle.
- A ctrl pop and the previous packet's final write may coincide; there is no bubble requirement beyond the 1-cycle IDLE pop.

Decomposition:
- Shared package ofm_pkg:
  - Field positions: CTRL_LEN_LSB/MSB, CTRL_DROP_BIT, BEAT_LAST_BIT, BEAT_KEEP_LSB/MSB.
  - State encodings: ST_IDLE, ST_XFER, ST_DROP.
  - Function len_to_keep(rem[3:0]).
- No sub-module needed. The keep generator stays a function in the package.

Test Plan:
- len=64, 8 beats, source last on beat 8 -> 8 writes, keep FF on all, last only on beat 8, pkt_cnt=1, errs 0.
- len=61, 8 beats (last beat keep 1F) -> final write keep=8'h1F, last=1, pkt_cnt=1.
- ctrl drop=1, len=100, 13 beats -> 13 pops, zero tx_fifo_wren, drop_cnt=1, next packet forwards normally.
- len=16 but 4 beats supplied (last on beat 4) -> 2 writes (second with last=1, keep FF), 2 beats flushed, len_err_cnt=1.
- len=40, last on beat 3 -> 3 writes ending last=1 with source keep, len_err_cnt=1, returns to IDLE.
- Random tx_fifo_afull/empty toggling over 50 packets, reset asserted mid-packet once -> scoreboard exact beats/order, all outputs 0 after reset, busy=0.
